// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and its datapath (slave).
// Carries instruction/status inputs, all control outputs, state code and the illegal flag.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic       pc_en;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [5:0] ALUOP;
    logic [1:0] PCSource;

    logic [3:0] state;
    logic       illegal;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
               ALUSrcA, ALUSrcB, ALUOP, PCSource, state, illegal
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite,
               ALUSrcA, ALUSrcB, ALUOP, PCSource, state, illegal
    );
endinterface

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath with a sticky illegal-opcode flag.
// Optional macro JUMP_EN adds the JUMP state for opcode 000010 (otherwise it is illegal).
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    localparam logic [3:0] S_FETCH   = 4'd0;
    localparam logic [3:0] S_DECODE  = 4'd1;
    localparam logic [3:0] S_MEMADR  = 4'd2;
    localparam logic [3:0] S_MEMRD   = 4'd3;
    localparam logic [3:0] S_MEMWB   = 4'd4;
    localparam logic [3:0] S_MEMWR   = 4'd5;
    localparam logic [3:0] S_EXEC    = 4'd6;
    localparam logic [3:0] S_ALUWB   = 4'd7;
    localparam logic [3:0] S_BRANCH  = 4'd8;
    localparam logic [3:0] S_ADDI_EX = 4'd10;
    localparam logic [3:0] S_ADDI_WB = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

`ifdef JUMP_EN
    localparam logic [3:0] S_JUMP   = 4'd9;
    localparam logic [5:0] OP_J     = 6'b000010;
`endif

    logic [3:0] state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       decode_illegal;

    logic       pc_en, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [5:0] alu_op;
    logic [1:0] pc_source;

    always_comb begin
        state_d        = S_FETCH;
        decode_illegal = 1'b0;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDI_EX;
`ifdef JUMP_EN
                    OP_J:          state_d = S_JUMP;
`endif
                    default: begin
                        state_d        = S_FETCH;
                        decode_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:  state_d = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:    state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_ADDI_EX: state_d = S_ADDI_WB;
            S_ADDI_WB: state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | decode_illegal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset masks every control line so no memory or register write can slip out mid-reset.
    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 6'd0;
        pc_source  = 2'b00;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = bus.mem_ready;
                    pc_en     = bus.mem_ready;
                end
                S_DECODE:  alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 6'd2;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = 6'd1;
                    pc_source = 2'b01;
                    pc_en     = bus.zero;
                end
`ifdef JUMP_EN
                S_JUMP: begin
                    pc_source = 2'b10;
                    pc_en     = 1'b1;
                end
`endif
                S_ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ADDI_WB: reg_write = 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.pc_en    = pc_en;
    assign bus.IorD     = iord;
    assign bus.MemRead  = mem_read;
    assign bus.MemWrite = mem_write;
    assign bus.IRWrite  = ir_write;
    assign bus.MemtoReg = mem_to_reg;
    assign bus.RegDst   = reg_dst;
    assign bus.RegWrite = reg_write;
    assign bus.ALUSrcA  = alu_src_a;
    assign bus.ALUSrcB  = alu_src_b;
    assign bus.ALUOP    = alu_op;
    assign bus.PCSource = pc_source;
    assign bus.state    = state_q;
    assign bus.illegal  = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: directed and random instructions against a per-instruction
// state-sequence model and a per-state control table; honours JUMP_EN like the design.
module tb_multicycle_control;
    logic clk = 1'b0;
    logic reset;

    multicycle_control_if bus ();

    multicycle_control dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_en;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       MemtoReg;
        logic       RegDst;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [5:0] ALUOP;
        logic [1:0] PCSource;
    } ctrl_t;

    typedef struct {
        int   st;
        logic mr;
    } step_t;

    step_t      plan[$];
    int         checks = 0;
    int         errors = 0;
    logic       model_illegal = 1'b0;
    logic [5:0] cur_op = 6'd0;
    logic       cur_zero = 1'b0;

    // Control lines each state must raise; everything unlisted stays 0.
    function automatic ctrl_t expected_ctrl(int st, logic mr, logic z);
        ctrl_t c;
        c = '0;
        case (st)
            0:  begin c.MemRead = 1; c.ALUSrcB = 2'b01; c.IRWrite = mr; c.pc_en = mr; end
            1:  c.ALUSrcB = 2'b11;
            2:  begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            3:  begin c.MemRead = 1; c.IorD = 1; end
            4:  begin c.RegWrite = 1; c.MemtoReg = 1; end
            5:  begin c.MemWrite = 1; c.IorD = 1; end
            6:  begin c.ALUSrcA = 1; c.ALUOP = 6'd2; end
            7:  begin c.RegWrite = 1; c.RegDst = 1; end
            8:  begin c.ALUSrcA = 1; c.ALUOP = 6'd1; c.PCSource = 2'b01; c.pc_en = z; end
            9:  begin c.PCSource = 2'b10; c.pc_en = 1; end
            10: begin c.ALUSrcA = 1; c.ALUSrcB = 2'b10; end
            11: c.RegWrite = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic ctrl_t observed_ctrl();
        ctrl_t c;
        c.pc_en    = bus.pc_en;
        c.IorD     = bus.IorD;
        c.MemRead  = bus.MemRead;
        c.MemWrite = bus.MemWrite;
        c.IRWrite  = bus.IRWrite;
        c.MemtoReg = bus.MemtoReg;
        c.RegDst   = bus.RegDst;
        c.RegWrite = bus.RegWrite;
        c.ALUSrcA  = bus.ALUSrcA;
        c.ALUSrcB  = bus.ALUSrcB;
        c.ALUOP    = bus.ALUOP;
        c.PCSource = bus.PCSource;
        return c;
    endfunction

    function automatic logic is_legal(logic [5:0] op);
        logic ok;
        ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
             (op == 6'b000100) || (op == 6'b001000);
`ifdef JUMP_EN
        ok = ok || (op == 6'b000010);
`endif
        return ok;
    endfunction

    task automatic check_vec(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(logic [5:0] op, logic z, logic mr);
        bus.opcode    = op;
        bus.zero      = z;
        bus.mem_ready = mr;
    endtask

    task automatic check_output(string tag, int exp_state, logic mr);
        ctrl_t obs_c;
        obs_c = observed_ctrl();
        check_vec($sformatf("%s/state", tag), {28'd0, bus.state}, exp_state);
        check_vec($sformatf("%s/ctrl@%0d", tag, exp_state), {13'd0, obs_c},
                  {13'd0, expected_ctrl(exp_state, mr, cur_zero)});
        check_vec($sformatf("%s/illegal", tag), {31'd0, bus.illegal}, {31'd0, model_illegal});
        check_vec($sformatf("%s/rd_wr_excl", tag), {31'd0, bus.MemRead & bus.MemWrite}, 32'd0);
    endtask

    // Expected cycle-by-cycle state walk of one instruction, derived from its opcode and stalls.
    task automatic build_plan(logic [5:0] op, logic z, int fetch_stalls, int mem_stalls);
        cur_op   = op;
        cur_zero = z;
        plan.delete();
        for (int i = 0; i < fetch_stalls; i++) plan.push_back('{0, 1'b0});
        plan.push_back('{0, 1'b1});
        plan.push_back('{1, 1'($urandom)});
        case (op)
            6'b000000: begin plan.push_back('{6, 1'($urandom)}); plan.push_back('{7, 1'($urandom)}); end
            6'b100011: begin
                plan.push_back('{2, 1'($urandom)});
                for (int i = 0; i < mem_stalls; i++) plan.push_back('{3, 1'b0});
                plan.push_back('{3, 1'b1});
                plan.push_back('{4, 1'($urandom)});
            end
            6'b101011: begin
                plan.push_back('{2, 1'($urandom)});
                for (int i = 0; i < mem_stalls; i++) plan.push_back('{5, 1'b0});
                plan.push_back('{5, 1'b1});
            end
            6'b000100: plan.push_back('{8, 1'($urandom)});
            6'b001000: begin plan.push_back('{10, 1'($urandom)}); plan.push_back('{11, 1'($urandom)}); end
`ifdef JUMP_EN
            6'b000010: plan.push_back('{9, 1'($urandom)});
`endif
            default: ;
        endcase
    endtask

    task automatic run_plan(string tag, int limit);
        for (int i = 0; i < plan.size() && i < limit; i++) begin
            apply_stimulus(cur_op, cur_zero, plan[i].mr);
            @(negedge clk);
            check_output(tag, plan[i].st, plan[i].mr);
            @(posedge clk);
            #1;
            if (plan[i].st == 1 && !is_legal(cur_op)) model_illegal = 1'b1;
        end
    endtask

    task automatic do_reset(string tag, int cycles, logic mr);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            bus.mem_ready = mr;
            @(negedge clk);
            check_vec($sformatf("%s/ctrl_in_reset", tag), {13'd0, observed_ctrl()}, 32'd0);
            if (i > 0) begin
                check_vec($sformatf("%s/state_in_reset", tag), {28'd0, bus.state}, 32'd0);
                check_vec($sformatf("%s/illegal_in_reset", tag), {31'd0, bus.illegal}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        model_illegal = 1'b0;
    endtask

    logic [5:0] op_table [7];

    initial begin
        op_table[0] = 6'b000000;
        op_table[1] = 6'b100011;
        op_table[2] = 6'b101011;
        op_table[3] = 6'b000100;
        op_table[4] = 6'b001000;
        op_table[5] = 6'b000010;
        op_table[6] = 6'b111111;

        apply_stimulus(6'd0, 1'b0, 1'b1);
        do_reset("por", 2, 1'b1);

        build_plan(6'b100011, 1'b0, 0, 0);  run_plan("lw", 1000);
        build_plan(6'b101011, 1'b0, 0, 3);  run_plan("sw_stall3", 1000);
        build_plan(6'b000100, 1'b1, 0, 0);  run_plan("beq_taken", 1000);
        build_plan(6'b000100, 1'b0, 0, 0);  run_plan("beq_not_taken", 1000);
        build_plan(6'b000000, 1'b0, 2, 0);  run_plan("rtype_fetch_stall", 1000);
        build_plan(6'b001000, 1'b0, 0, 0);  run_plan("addi", 1000);
        build_plan(6'b111111, 1'b0, 0, 0);  run_plan("illegal_op", 1000);
        build_plan(6'b100011, 1'b0, 0, 1);  run_plan("lw_after_illegal", 1000);
        build_plan(6'b000010, 1'b0, 0, 0);  run_plan("jump", 1000);

        // lw stalled in MEMRD, then reset aborts it
        build_plan(6'b100011, 1'b0, 0, 5);  run_plan("lw_abort", 6);
        do_reset("rst_memrd", 2, 1'b0);
        // sw stalled in MEMWR, then a single-cycle reset aborts it
        build_plan(6'b101011, 1'b0, 0, 5);  run_plan("sw_abort", 5);
        do_reset("rst_memwr", 1, 1'b0);
        build_plan(6'b000000, 1'b0, 0, 0);  run_plan("post_reset_rtype", 1000);

        for (int n = 0; n < 120; n++) begin
            logic [5:0] op;
            op = op_table[$urandom_range(0, 6)];
            if ($urandom_range(0, 9) == 0) op = 6'($urandom);
            build_plan(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) begin
                run_plan("rand_abort", $urandom_range(1, plan.size()));
                do_reset("rand_reset", $urandom_range(1, 2), 1'($urandom));
            end else begin
                run_plan("rand", 1000);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port opcode, input, 6, instruction[31:26] from instruction register.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have port mem_ready, input, 1, memory access completes this cycle.
REQ-006 SHALL have outputs pc_en, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, each 1 bit, meaning as in the datapath control set.
REQ-007 SHALL have outputs ALUSrcB (2: 00 reg, 01 const 4, 10 sign-ext imm, 11 imm<<2), ALUOP (6: 0 add, 1 sub, 2 use funct), PCSource (2: 00 ALU, 01 ALUOut, 10 jump target).
REQ-008 SHALL have outputs state (4, current state code) and illegal (1, sticky illegal-opcode flag).

Function
REQ-009 SHALL be a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11; codes 12-15 unused.
REQ-010 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOP=0, PCSource=00; IRWrite=pc_en=mem_ready; stays in FETCH while mem_ready=0, goes to DECODE when 1.
REQ-011 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOP=0; next by opcode: 000000->EXEC, 100011/101011->MEMADR, 000100->BRANCH, 001000->ADDI_EX, 000010->JUMP (see REQ-022), other->FETCH with illegal set.
REQ-012 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOP=0; next MEMRD if opcode=100011, else MEMWR.
REQ-013 MEMRD: MemRead=1, IorD=1; holds while mem_ready=0; then MEMWB.
REQ-014 MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; next FETCH.
REQ-015 MEMWR: MemWrite=1, IorD=1; holds while mem_ready=0; then FETCH.
REQ-016 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOP=2; next ALUWB. ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; next FETCH.
REQ-017 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOP=1, PCSource=01, pc_en=zero; next FETCH.
REQ-018 ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOP=0; next ADDI_WB. ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0; next FETCH.
REQ-019 Every output not listed for a state SHALL be 0 in that state; MemRead and MemWrite SHALL never be 1 together.
REQ-020 Unused state codes SHALL transition to FETCH next cycle with all outputs 0.
REQ-021 Latencies with mem_ready held 1: R-type 4 cycles, lw 5, sw 4, beq 3, addi 4, j 3; each extra mem_ready=0 cycle in a memory state adds one cycle.

Configuration
REQ-022 With JUMP_EN defined, opcode 000010 SHALL go DECODE->JUMP; JUMP: PCSource=10, pc_en=1; next FETCH. Without JUMP_EN, JUMP state SHALL not exist and 000010 SHALL be treated as illegal.

Reset
REQ-023 While reset=1 at a rising edge, state SHALL become FETCH and illegal SHALL become 0.
REQ-024 While reset=1, all control outputs SHALL be forced 0 combinationally (no memory or register write during reset), regardless of state.
REQ-025 Reset asserted mid-instruction (any state, including a stalled MEMWR) SHALL abort it; first post-reset cycle is FETCH.
REQ-026 illegal SHALL stay 1 once set until reset; execution continues from FETCH.

Verification
REQ-027 reset=1 two cycles, then 0, mem_ready=1 -> state=0, MemRead=1, IRWrite=1, pc_en=1 in first post-reset cycle.
REQ-028 opcode=100011, mem_ready=1 -> state sequence 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4.
REQ-029 opcode=101011, mem_ready=0 for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles, IorD=1, then state 0.
REQ-030 opcode=000100 with zero=1 -> pc_en=1, PCSource=01 in state 8; repeat with zero=0 -> pc_en=0.
REQ-031 opcode=111111 -> state 0,1,0; illegal=1 from next cycle and remains 1 until reset; opcode=000010 -> state 9 with JUMP_EN, illegal=1 without.
REQ-032 reset=1 during stalled MEMRD -> next cycle state=0, all outputs 0 while reset high, illegal=0.
